// File: rtl/draw_pkg.sv
// Shared constants, conversion FSM encoding and the BCD adjust helper for the
// draw display slice.
package draw_pkg;
  localparam int         MAX_DRAWS = 7;
  localparam int         VALUE_W   = 7;
  localparam int         MAX_VALUE = 92;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } conv_state_t;

  // Shift-add-3 pre-shift correction: any BCD nibble of 5 or more gets +3.
  function automatic logic [7:0] bcd_adjust(input logic [7:0] bcd);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
    hi = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
    return {hi, lo};
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// Combinational decimal digit to active-low seven-segment {g..a} decoder with
// a blank override; non-decimal codes also blank.
module seg7_decode
  import draw_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Digit lookup, blank takes priority.
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (digit)
        4'd0:    seg = 7'h40;
        4'd1:    seg = 7'h79;
        4'd2:    seg = 7'h24;
        4'd3:    seg = 7'h30;
        4'd4:    seg = 7'h19;
        4'd5:    seg = 7'h12;
        4'd6:    seg = 7'h02;
        4'd7:    seg = 7'h78;
        4'd8:    seg = 7'h00;
        4'd9:    seg = 7'h10;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/draw_display.sv
// Captures drawn numbers into a small history, converts the viewed entry to BCD
// with a sequential shift-add-3 engine and drives three active-low HEX digits.
module draw_display
  import draw_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               display_active,
  input  logic [VALUE_W-1:0] count_value,
  input  logic               key_browse,
  output logic [6:0]         hex0,
  output logic [6:0]         hex1,
  output logic [6:0]         hex2,
  output logic [2:0]         draw_count,
  output logic               full,
  output logic               busy,
  output logic               error
);

  localparam logic [VALUE_W-1:0] MAX_VALUE_V = VALUE_W'(MAX_VALUE);
  localparam logic [2:0]         LAST_SHIFT  = 3'(VALUE_W - 1);

  logic [VALUE_W-1:0] history_r [MAX_DRAWS];
  logic [2:0]         draw_count_r;
  logic [2:0]         view_idx_r;
  logic               full_r;
  logic               error_r;
  logic               key_prev_r;
  conv_state_t        state_r;
  logic               busy_r;
  logic               pending_r;
  logic [VALUE_W-1:0] bin_r;
  logic [7:0]         bcd_r;
  logic [2:0]         shift_cnt_r;
  logic [6:0]         hex0_r;
  logic [6:0]         hex1_r;
  logic [6:0]         hex2_r;

  logic               value_legal_s;
  logic               capture_s;
  logic               browse_s;
  logic               request_s;
  logic [2:0]         view_prev_s;
  logic [7:0]         bcd_adj_s;
  logic [6:0]         seg_units_s;
  logic [6:0]         seg_tens_s;
  logic [6:0]         seg_slot_s;

  // Capture/browse qualification; a capture in the same cycle drops the browse edge.
  always_comb begin
    value_legal_s = (count_value != '0) && (count_value <= MAX_VALUE_V);
    capture_s     = display_active && value_legal_s && !full_r;
    browse_s      = key_browse && !key_prev_r && (draw_count_r != 3'd0) && !capture_s;
    request_s     = capture_s || browse_s;
    if (view_idx_r == 3'd0) begin
      view_prev_s = draw_count_r - 3'd1;
    end else begin
      view_prev_s = view_idx_r - 3'd1;
    end
    bcd_adj_s = bcd_adjust(bcd_r);
  end

  seg7_decode u_seg_units (
    .digit (bcd_r[3:0]),
    .blank (1'b0),
    .seg   (seg_units_s)
  );

  seg7_decode u_seg_tens (
    .digit (bcd_r[7:4]),
    .blank (bcd_r[7:4] == 4'd0),
    .seg   (seg_tens_s)
  );

  seg7_decode u_seg_slot (
    .digit ({1'b0, view_idx_r + 3'd1}),
    .blank (1'b0),
    .seg   (seg_slot_s)
  );

  // History store, occupancy, view pointer, sticky error and browse edge history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_DRAWS; i++) begin
        history_r[i] <= '0;
      end
      draw_count_r <= 3'd0;
      view_idx_r   <= 3'd0;
      full_r       <= 1'b0;
      error_r      <= 1'b0;
      key_prev_r   <= 1'b0;
    end else begin
      key_prev_r <= key_browse;
      if (display_active && !value_legal_s) begin
        error_r <= 1'b1;
      end
      if (capture_s) begin
        history_r[draw_count_r] <= count_value;
        draw_count_r            <= draw_count_r + 3'd1;
        view_idx_r              <= draw_count_r;
        full_r                  <= (draw_count_r == 3'(MAX_DRAWS - 1));
      end else if (browse_s) begin
        view_idx_r <= view_prev_s;
      end
    end
  end

  // Conversion FSM; requests arriving while busy collapse into one re-run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      pending_r   <= 1'b0;
      bin_r       <= '0;
      bcd_r       <= 8'd0;
      shift_cnt_r <= 3'd0;
      hex0_r      <= SEG_BLANK;
      hex1_r      <= SEG_BLANK;
      hex2_r      <= SEG_BLANK;
    end else begin
      case (state_r)
        IDLE: begin
          if (request_s) begin
            state_r <= LOAD;
            busy_r  <= 1'b1;
          end
        end
        LOAD: begin
          bin_r       <= history_r[view_idx_r];
          bcd_r       <= 8'd0;
          shift_cnt_r <= 3'd0;
          state_r     <= SHIFT;
          if (request_s) begin
            pending_r <= 1'b1;
          end
        end
        SHIFT: begin
          bcd_r       <= {bcd_adj_s[6:0], bin_r[VALUE_W-1]};
          bin_r       <= {bin_r[VALUE_W-2:0], 1'b0};
          shift_cnt_r <= shift_cnt_r + 3'd1;
          if (shift_cnt_r == LAST_SHIFT) begin
            state_r <= DONE;
          end
          if (request_s) begin
            pending_r <= 1'b1;
          end
        end
        DONE: begin
          hex0_r    <= seg_units_s;
          hex1_r    <= seg_tens_s;
          hex2_r    <= seg_slot_s;
          pending_r <= 1'b0;
          if (pending_r || request_s) begin
            state_r <= LOAD;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          busy_r    <= 1'b0;
          pending_r <= 1'b0;
        end
      endcase
    end
  end

  assign hex0       = hex0_r;
  assign hex1       = hex1_r;
  assign hex2       = hex2_r;
  assign draw_count = draw_count_r;
  assign full       = full_r;
  assign busy       = busy_r;
  assign error      = error_r;

endmodule
